sort_result_streamer: RTL and testbench
=======================================

// Module: sort_result_streamer
// PURPOSE
// - Consumer of the heptagon area sorter's output. Captures the sorted area/index arrays once
//   the sorter raises its valid flag and streams them one entry per handshake, largest area first.
// - Sits between the sorter and downstream logic (display, report or next-stage selection).
// - Decouples the downstream stage from the sorter's level-held result.
// PARAMETERS
// - N       5   entries per sorted set
// - AREA_W  19  area width, unsigned
// - IDX_W   3   heptagon index width
// PORTS
// - clk        in   1           clock, rising edge
// - reset      in   1           synchronous, active-high
// - valid_on   in   1           sorter result valid, level; held high after sort completes
// - area_in    in   N*AREA_W    sorted areas, entry k at [k*AREA_W +: AREA_W]; k=0 is largest
// - index_in   in   N*IDX_W     sorted indices, entry k at [k*IDX_W +: IDX_W]
// - out_valid  out  1           output beat valid
// - out_ready  in   1           downstream accepts beat
// - out_area   out  AREA_W      area of current beat
// - out_index  out  IDX_W       heptagon index of current beat
// - out_rank   out  3           rank of current beat, 0..N-1
// - out_last   out  1           high with out_valid on rank N-1
// - busy       out  1           capture taken, stream not finished
// - done       out  1           one-cycle pulse after the last beat is accepted
// - order_err  out  1           ordering flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0; FSM goes to IDLE; shadow registers cleared; valid_on edge detector
//   cleared (prev=0).
// - Reset takes priority over every other event in the same cycle. Reset mid-stream aborts
//   the stream with no done pulse.
// - FSM states: IDLE, SEND, DONE, WAITLOW.
// - IDLE:
//   - Rising edge of valid_on (valid_on=1, prev=0) copies area_in/index_in into shadow regs.
//   - Same cycle: rank<=0, busy<=1, next state SEND.
//   - Result: out_valid is high the cycle after the edge. Latency edge->first beat = 1 clk.
// - SEND:
//   - out_valid=1; out_area/out_index = shadow[rank]; out_last = (rank==N-1).
//   - Outputs are stable while out_valid && !out_ready.
//   - Beat is accepted when out_valid && out_ready; then rank<=rank+1.
//   - Accepting rank N-1: out_valid<=0, busy<=0, done<=1, next state DONE.
//   - Full-throughput stream: N beats in N consecutive clks.
// - DONE: done<=0. Next state WAITLOW if valid_on still high, else IDLE.
// - WAITLOW: wait for valid_on=0, then go to IDLE. A held-high valid_on never restarts a stream.
// - valid_on falling mid-stream: no effect; the stream continues from the shadow copy.
// - New rising edge while SEND/DONE/WAITLOW: ignored (no re-capture, no queueing).
// - Input buses are sampled only in the capture cycle; later changes do not affect beats.
// - Equal areas are streamed in input order; no reordering or tie-break is performed.
// - rank counter is 3 bits and never exceeds N-1; N is limited to 2..8.
// CONFIGURATION
// - Macro SORT_STREAM_ORDER_CHECK_EN.
// - Defined:
//   - In the capture cycle, order_err<=1 if any area_in[k] < area_in[k+1] (k=0..N-2,
//     unsigned compare).
//   - order_err is sticky until the next capture or reset.
//   - Streaming is unaffected.
// - Not defined: order_err is tied to 0; no comparator logic is built.
// TESTING
// - T1 reset: hold reset 2 clks, valid_on=1 -> all outputs 0, no beat until valid_on falls and rises.
// - T2 full rate: areas {900,700,500,300,100}, idx {4,1,0,3,2}, out_ready=1, valid_on 0->1
//   -> beats (900,4,r0)..(100,2,r4) on 5 consecutive clks; out_last on r4; done 1 clk after.
// - T3 backpressure: as T2 with out_ready low on clks 2-4 -> beat r1 held stable, order
//   unchanged, done after 5th accept.
// - T4 level hold: valid_on kept high 50 clks after T2 -> exactly 5 beats. Drop and re-raise
//   with new data {50,40,30,20,10} -> new stream of 5.
// - T5 reset mid-stream: reset asserted after r2 is accepted -> next clk out_valid=0, busy=0,
//   done never pulses.
// - T6 (with SORT_STREAM_ORDER_CHECK_EN): areas {100,300,200,50,10} -> order_err=1, 5 beats
//   still streamed. Next capture with sorted data -> order_err=0.

Source files
------------

// File: rtl/sort_result_streamer_if.sv
// Beat interface between the sort result streamer and its downstream consumer.
// One entry of the sorted set per handshake (out_valid && out_ready).
interface sort_result_streamer_if #(
    parameter int AREA_W = 19,
    parameter int IDX_W  = 3
);
    logic              out_valid;
    logic              out_ready;
    logic [AREA_W-1:0] out_area;
    logic [IDX_W-1:0]  out_index;
    logic [2:0]        out_rank;
    logic              out_last;

    modport master (
        output out_valid, out_area, out_index, out_rank, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_area, out_index, out_rank, out_last,
        output out_ready
    );
endinterface

// File: rtl/sort_result_streamer.sv
// sort_result_streamer: captures the heptagon area sorter's level-held result on the
// rising edge of valid_on and streams it one entry per handshake, largest area first.
// Optional feature: define SORT_STREAM_ORDER_CHECK_EN to build the capture-time
// ordering check that drives order_err; otherwise order_err is tied low.
module sort_result_streamer #(
    parameter int N      = 5,
    parameter int AREA_W = 19,
    parameter int IDX_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_on,
    input  logic [N*AREA_W-1:0]   area_in,
    input  logic [N*IDX_W-1:0]    index_in,
    sort_result_streamer_if.master stream,
    output logic                  busy,
    output logic                  done,
    output logic                  order_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] WAITLOW = 2'd3;

    localparam logic [2:0] LAST_RANK = 3'(N - 1);

    logic [1:0]        state;
    logic [2:0]        rank;
    logic              beat_valid;
    logic              valid_prev;
    logic              armed;
    logic              capture;
    logic              accept;
    logic [AREA_W-1:0] shadow_area  [N];
    logic [IDX_W-1:0]  shadow_index [N];
    logic [AREA_W-1:0] beat_area;
    logic [IDX_W-1:0]  beat_index;
    logic              beat_last;

    // A valid_on held high through reset is a stale result, so a capture also needs
    // valid_on to have been seen low at least once since reset (armed).
    assign capture = (state == IDLE) && valid_on && !valid_prev && armed;
    assign accept  = beat_valid && stream.out_ready;

    // Edge detector history and the post-reset arming flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            valid_prev <= 1'b0;
            armed      <= 1'b0;
        end else begin
            valid_prev <= valid_on;
            if (!valid_on) armed <= 1'b1;
        end
    end

    // Shadow copy of the sorted result, loaded only in the capture cycle.
    always_ff @(posedge clk) begin
        // NOTE: the shadow arrays are cleared on reset on purpose so a post-reset idle
        // output is all zeros; drop this loop if that guarantee is not wanted.
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                shadow_area[k]  <= '0;
                shadow_index[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N; k++) begin
                shadow_area[k]  <= area_in[k*AREA_W +: AREA_W];
                shadow_index[k] <= index_in[k*IDX_W +: IDX_W];
            end
        end
    end

    // Stream control FSM: capture, send N beats, pulse done, then wait for valid_on low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rank       <= '0;
            beat_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        rank       <= '0;
                        beat_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (rank == LAST_RANK) begin
                            rank       <= '0;
                            beat_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            rank <= rank + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= valid_on ? WAITLOW : IDLE;
                end
                WAITLOW: begin
                    if (!valid_on) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat payload: the shadow entry at the current rank, zero while no beat is offered.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // value unassigned and no latch is inferred.
        beat_area  = '0;
        beat_index = '0;
        beat_last  = 1'b0;
        if (beat_valid) begin
            beat_area  = shadow_area[rank];
            beat_index = shadow_index[rank];
            beat_last  = (rank == LAST_RANK);
        end
    end

    assign stream.out_valid = beat_valid;
    assign stream.out_area  = beat_area;
    assign stream.out_index = beat_index;
    assign stream.out_rank  = rank;
    assign stream.out_last  = beat_last;

`ifdef SORT_STREAM_ORDER_CHECK_EN
    logic unsorted;

    // Any adjacent pair rising in area means the sorter's output is not descending.
    always_comb begin
        unsorted = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (area_in[k*AREA_W +: AREA_W] < area_in[(k+1)*AREA_W +: AREA_W]) unsorted = 1'b1;
        end
    end

    // Ordering flag, re-evaluated at each capture and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            order_err <= 1'b0;
        end else if (capture) begin
            order_err <= unsorted;
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed bench for sort_result_streamer: reset, full-rate stream, backpressure,
// level-held valid_on, reset mid-stream and the capture-time ordering flag.
module tb_sort_result_streamer;

    localparam int N      = 5;
    localparam int AREA_W = 19;
    localparam int IDX_W  = 3;
`ifdef SORT_STREAM_ORDER_CHECK_EN
    localparam logic ORDER_CHK = 1'b1;
`else
    localparam logic ORDER_CHK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                valid_on;
    logic [N*AREA_W-1:0] area_in;
    logic [N*IDX_W-1:0]  index_in;
    logic                busy;
    logic                done;
    logic                order_err;

    int n_cmp = 0;
    int n_err = 0;

    sort_result_streamer_if #(.AREA_W(AREA_W), .IDX_W(IDX_W)) sif ();

    sort_result_streamer #(.N(N), .AREA_W(AREA_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_on  (valid_on),
        .area_in   (area_in),
        .index_in  (index_in),
        .stream    (sif.master),
        .busy      (busy),
        .done      (done),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input logic [AREA_W-1:0] a [N], input logic [IDX_W-1:0] ix [N]);
        for (int k = 0; k < N; k++) begin
            area_in[k*AREA_W +: AREA_W] = a[k];
            index_in[k*IDX_W +: IDX_W]  = ix[k];
        end
    endtask

    // Present new data with a rising valid_on; capture happens on the following posedge.
    task automatic raise(input logic [AREA_W-1:0] a [N], input logic [IDX_W-1:0] ix [N]);
        @(negedge clk);
        load(a, ix);
        valid_on = 1'b1;
    endtask

    task automatic drop(input int cycles);
        @(negedge clk);
        valid_on = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // Consume one stream: ready_mask bit c drives out_ready in cycle c. The beat must be
    // offered in cycle 0 (one clock after the edge); inputs are scrambled after capture.
    task automatic run_stream(input string tag,
                              input logic [AREA_W-1:0] ea [N], input logic [IDX_W-1:0] ei [N],
                              input logic [15:0] ready_mask, input int exp_span,
                              input logic exp_err);
        int beats = 0;
        int first_acc = -1;
        int last_acc = -1;
        int first_valid = -1;
        int cyc = 0;
        while (beats < N && cyc < 40) begin
            @(negedge clk);
            sif.out_ready = (cyc < 16) ? ready_mask[cyc] : 1'b1;
            if (sif.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check({tag, "_area"},  32'(sif.out_area),  32'(ea[beats]));
                check({tag, "_index"}, 32'(sif.out_index), 32'(ei[beats]));
                check({tag, "_rank"},  32'(sif.out_rank),  32'(beats));
                check({tag, "_last"},  32'(sif.out_last),  32'(beats == N - 1));
                check({tag, "_busy"},  32'(busy),          32'd1);
                if (sif.out_ready) begin
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    beats++;
                end
            end
            if (cyc == 0) begin
                area_in  = '1;
                index_in = '0;
            end
            cyc++;
        end
        check({tag, "_beats"}, 32'(beats), 32'(N));
        check({tag, "_latency"}, 32'(first_valid), 32'd0);
        check({tag, "_span"}, 32'(last_acc - first_acc), 32'(exp_span));
        @(negedge clk);
        sif.out_ready = 1'b1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_valid_after"}, 32'(sif.out_valid), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_order_err"}, 32'(order_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    logic [AREA_W-1:0] a_sorted [N];
    logic [IDX_W-1:0]  i_sorted [N];
    logic [AREA_W-1:0] a_small  [N];
    logic [IDX_W-1:0]  i_small  [N];
    logic [AREA_W-1:0] a_bad    [N];
    int                cnt;

    initial begin
        a_sorted = '{900, 700, 500, 300, 100};
        i_sorted = '{4, 1, 0, 3, 2};
        a_small  = '{50, 40, 30, 20, 10};
        i_small  = '{6, 5, 4, 3, 2};
        a_bad    = '{100, 300, 200, 50, 10};

        // T1: reset with valid_on high; held-high level must not start a stream.
        reset = 1'b1;
        valid_on = 1'b1;
        sif.out_ready = 1'b1;
        load(a_sorted, i_sorted);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(sif.out_valid), 32'd0);
        check("rst_area",  32'(sif.out_area),  32'd0);
        check("rst_index", 32'(sif.out_index), 32'd0);
        check("rst_rank",  32'(sif.out_rank),  32'd0);
        check("rst_last",  32'(sif.out_last),  32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_done",  32'(done),          32'd0);
        check("rst_oerr",  32'(order_err),     32'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (sif.out_valid || busy) cnt++;
        end
        check("rst_no_beat", 32'(cnt), 32'd0);
        drop(1);

        // T2: full-rate stream after valid_on 0->1.
        raise(a_sorted, i_sorted);
        run_stream("t2", a_sorted, i_sorted, 16'hFFFF, 4, 1'b0);

        // T4: valid_on held high for 50 clocks produces no further beats.
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (sif.out_valid || done) cnt++;
        end
        check("t4_hold_no_beat", 32'(cnt), 32'd0);
        drop(2);
        raise(a_small, i_small);
        run_stream("t4", a_small, i_small, 16'hFFFF, 4, 1'b0);
        drop(2);

        // T3: out_ready low in stream cycles 1..3 holds beat r1 stable.
        raise(a_sorted, i_sorted);
        run_stream("t3", a_sorted, i_sorted, 16'hFFF1, 7, 1'b0);
        drop(2);

        // T5: reset right after r2 is accepted aborts the stream without done.
        raise(a_sorted, i_sorted);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            sif.out_ready = 1'b1;
            check("t5_rank", 32'(sif.out_rank), 32'(r));
        end
        @(negedge clk);
        reset = 1'b1;
        valid_on = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(sif.out_valid), 32'd0);
        check("t5_busy",  32'(busy),          32'd0);
        check("t5_done",  32'(done),          32'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || sif.out_valid) cnt++;
        end
        check("t5_no_done", 32'(cnt), 32'd0);

        // T6: unsorted capture flags order_err (when built) but still streams.
        raise(a_bad, i_sorted);
        run_stream("t6", a_bad, i_sorted, 16'hFFFF, 4, ORDER_CHK);
        drop(2);
        raise(a_sorted, i_sorted);
        run_stream("t6_clear", a_sorted, i_sorted, 16'hFFFF, 4, 1'b0);
        drop(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
